// File: rtl/pb_bounce_gen.sv
// pb_bounce_gen: push-button emulator. A one-cycle trig produces a bouncy
// press, a clean hold of HOLD_CYC cycles and a bouncy release on pb_out.
// Bounce segment lengths come from a 16-bit Galois LFSR (1..2^BOUNCE_W cycles).
// Build option PB_BOUNCE_FIXED_EN: when defined, every bounce segment is
// exactly 2^BOUNCE_W cycles, which makes the waveform fully deterministic.
module pb_bounce_gen #(
  parameter int unsigned BOUNCE_PAIRS = 3,
  parameter int unsigned BOUNCE_W     = 4,
  parameter int unsigned HOLD_CYC     = 100,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pb_out,
  output logic busy,
  output logic done
);

  localparam int unsigned IVL_W   = BOUNCE_W + 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int unsigned CNT_W   = (IVL_W > HOLD_W) ? IVL_W : HOLD_W;
  localparam int unsigned TOG_MAX = 2 * BOUNCE_PAIRS;
  localparam int unsigned TOG_W   = (TOG_MAX < 2) ? 1 : $clog2(TOG_MAX + 1);
  localparam int unsigned TOG_PEN = (TOG_MAX == 0) ? 0 : TOG_MAX - 1;
  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] TAPS    = 16'hB400;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_B, HOLD, REL_B} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic               pb_q, pb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   ivl;
  logic               seg_end;
  logic               last_tog;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

`ifdef PB_BOUNCE_FIXED_EN
  assign ivl = CNT_W'(1 << BOUNCE_W);
`else
  assign ivl = CNT_W'(lfsr_q[BOUNCE_W-1:0]) + ONE;
`endif

  // a segment loaded with N ends on the N-th edge after the load
  assign seg_end  = (cnt_q == ONE);
  assign last_tog = (tog_q == TOG_W'(TOG_PEN));

  // state and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      tog_q   <= '0;
      pb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      pb_q    <= pb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // next-state: trig only matters in IDLE, so it is dropped while busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig) state_d = (BOUNCE_PAIRS == 0) ? HOLD : PRESS_B;
      PRESS_B: if (seg_end && last_tog) state_d = HOLD;
      HOLD:    if (seg_end) state_d = (BOUNCE_PAIRS == 0) ? IDLE : REL_B;
      REL_B:   if (seg_end && last_tog) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the counters and registered outputs
  always_comb begin
    pb_d   = pb_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    tog_d  = tog_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          pb_d   = 1'b1;
          busy_d = 1'b1;
          tog_d  = '0;
          cnt_d  = (BOUNCE_PAIRS == 0) ? HOLD_LD : ivl;
        end
      end
      PRESS_B, REL_B: begin
        if (seg_end) begin
          // even toggle count leaves pb_out at its segment-start level
          pb_d  = ~pb_q;
          tog_d = tog_q + TOG_W'(1);
          if (last_tog) begin
            if (state_q == PRESS_B) begin
              cnt_d = HOLD_LD;
            end else begin
              busy_d = 1'b0;
              done_d = 1'b1;
              cnt_d  = '0;
            end
          end else begin
            cnt_d = ivl;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (seg_end) begin
          pb_d  = 1'b0;
          tog_d = '0;
          if (BOUNCE_PAIRS == 0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = ivl;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        pb_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign pb_out = pb_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
